alarm_ring_controller: RTL
==========================

Name: alarm_ring_controller

Overview:
- Sequences the alarm sounder once the running time matches the stored alarm time.
- Handles ring cadence, snooze (limited count), stop, and auto-timeout.
- Sits between the time/alarm comparator and the buzzer/LED outputs of the clock top level. Replaces ad-hoc sound gating with a dedicated FSM.
- Runs in the 200 Hz system domain; 1 Hz timing arrives as a strobe.

Parameters:
- RING_TIMEOUT_S, 60: ring duration in seconds before automatic stop.
- SNOOZE_S, 300: snooze duration in seconds.
- MAX_SNOOZE, 3: snoozes allowed per alarm event (1..7).

Ports:
- clk  in  1  system clock (200 Hz domain).
- reset  in  1  synchronous, active-high reset.
- tick_1hz  in  1  single-cycle strobe, once per second, synchronous to clk.
- alarm_en  in  1  alarm armed (level).
- alarm_match  in  1  level, high while time == alarm time and seconds == 0.
- btn_snooze  in  1  debounced single-cycle press pulse.
- btn_stop  in  1  debounced single-cycle press pulse.
- sound  out  1  buzzer drive, registered.
- ringing  out  1  high in RING, registered.
- snoozing  out  1  high in SNOOZE, registered.
- snooze_left  out  3  snoozes remaining, registered.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: state = IDLE; sound, ringing, snoozing, beep_phase and match_q are 0; snooze_left = 0; both timers are 0.
- Edge detection: match_q registers alarm_match. Trigger = alarm_match & ~match_q, so one trigger per match window.
- Priority each cycle: reset > alarm_en==0 (force IDLE) > btn_stop > btn_snooze > timer expiry > trigger.
- IDLE:
  - If trigger & alarm_en: go to RING.
  - Load ring_cnt = RING_TIMEOUT_S, snooze_left = MAX_SNOOZE, beep_phase = 1.
- RING:
  - sound = beep_phase. beep_phase toggles on each tick_1hz (1 s on / 1 s off, starting on).
  - ring_cnt decrements on tick_1hz. The tick that takes ring_cnt 1 -> 0 means timeout -> IDLE.
  - btn_stop -> IDLE.
  - btn_snooze with snooze_left > 0 -> SNOOZE. Load snooze_cnt = SNOOZE_S and decrement snooze_left.
  - btn_snooze with snooze_left == 0 is ignored.
  - Simultaneous stop and snooze: stop wins.
- SNOOZE:
  - sound = 0.
  - snooze_cnt decrements on tick_1hz. The tick that takes it 1 -> 0 goes to RING: reload ring_cnt, beep_phase = 1.
  - btn_stop -> IDLE. btn_snooze is ignored.
- Trigger while in RING or SNOOZE is ignored: no reload, no counter change.
- Button press coincident with tick_1hz: the button transition wins and the tick is discarded for that cycle.
- All outputs update one clk after the causing input, i.e. latency 1 cycle.
- On entry to IDLE: sound = 0, snooze_left = 0.
- alarm_en falling mid-ring or mid-snooze: IDLE on the next edge, sound = 0 that same edge.
- Widths:
  - Timers are $clog2(max(RING_TIMEOUT_S, SNOOZE_S)+1) bits, unsigned.
  - Timers never decrement below 0.
  - snooze_left saturates at 0.

Optional Feature:
- Macro ALARM_AUTO_SNOOZE_EN.
- Defined: a ring timeout with snooze_left > 0 enters SNOOZE, exactly as a btn_snooze press would, including the decrement. Timeout with snooze_left == 0 goes to IDLE.
- Undefined: a ring timeout always goes to IDLE.

Decomposition:
- Shared package holds:
  - State enum IDLE/RING/SNOOZE, encoded 2'b00/2'b01/2'b10.
  - Default timing constants for RING_TIMEOUT_S, SNOOZE_S and MAX_SNOOZE.
  - The timer-width function.
- One sub-module, sec_down_timer.
  - Inputs: load, load value, tick, clear.
  - Outputs: count and expire pulse (tick while count == 1).
  - Instantiated twice: ring_cnt and snooze_cnt.

Test Plan:
Use RING_TIMEOUT_S=4, SNOOZE_S=3, MAX_SNOOZE=2 and a tick every 10 clk.
1. Trigger with alarm_en=1 -> ringing=1 next clk, snooze_left=2; sound pattern is 1,0,1,0 across 4 ticks; after the 4th tick ringing=0 and sound=0.
2. Trigger, then btn_snooze after 1 tick -> snoozing=1, snooze_left=1, sound=0; after 3 ticks ringing=1 with sound=1.
3. Snooze twice, then btn_snooze in the third RING -> ignored, ringing stays 1, snooze_left=0; btn_stop -> IDLE.
4. btn_stop and btn_snooze in the same clk during RING -> IDLE, snoozing never asserts.
5. alarm_match held high for 10 clk -> exactly one trigger; drop alarm_en mid-ring -> IDLE next clk, sound=0.
6. With ALARM_AUTO_SNOOZE_EN defined: let RING time out -> SNOOZE with snooze_left=1. Without the macro: IDLE.

Source files
------------

// File: rtl/alarm_ring_controller_pkg.sv
// ============================================================================
// alarm_ring_controller_pkg : shared state encoding, default timing, timer width
// Rev 1.0
// ============================================================================
`default_nettype none

package alarm_ring_controller_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RING   = 2'b01,
    SNOOZE = 2'b10
  } state_t;

  localparam int DEF_RING_TIMEOUT_S = 60;
  localparam int DEF_SNOOZE_S       = 300;
  localparam int DEF_MAX_SNOOZE     = 3;

  // One timer width serves both counters so they can share the sub-module.
  function automatic int timer_width(input int ring_s, input int snooze_s);
    int longest;
    longest = (ring_s > snooze_s) ? ring_s : snooze_s;
    return $clog2(longest + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_ring_controller_sec_down_timer.sv
// ============================================================================
// sec_down_timer : loadable seconds down-counter with expiry pulse on 1 -> 0
// Rev 1.0
// ============================================================================
`default_nettype none

module sec_down_timer
  import alarm_ring_controller_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             tick,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             expire
);

  assign expire = tick & (count == WIDTH'(1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/alarm_ring_controller.sv
// ============================================================================
// alarm_ring_controller : ring cadence, limited snooze, stop and auto-timeout
// Option macro ALARM_AUTO_SNOOZE_EN turns a ring timeout into a snooze. Rev 1.0
// ============================================================================
`default_nettype none

module alarm_ring_controller
  import alarm_ring_controller_pkg::*;
#(
  parameter int RING_TIMEOUT_S = DEF_RING_TIMEOUT_S,
  parameter int SNOOZE_S       = DEF_SNOOZE_S,
  parameter int MAX_SNOOZE     = DEF_MAX_SNOOZE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       alarm_en,
  input  logic       alarm_match,
  input  logic       btn_snooze,
  input  logic       btn_stop,
  output logic       sound,
  output logic       ringing,
  output logic       snoozing,
  output logic [2:0] snooze_left
);

  localparam int             TW          = timer_width(RING_TIMEOUT_S, SNOOZE_S);
  localparam logic [TW-1:0]  RING_LOAD   = TW'(RING_TIMEOUT_S);
  localparam logic [TW-1:0]  SNOOZE_LOAD = TW'(SNOOZE_S);
  localparam logic [2:0]     SNOOZE_INIT = 3'(MAX_SNOOZE);

  state_t        state, state_n;
  logic          match_q;
  logic          beep_phase, beep_n;
  logic [2:0]    snooze_left_n;
  logic          trigger, snooze_ok, auto_snooze;
  logic          to_idle, to_snooze;
  logic          ring_load, ring_clear, ring_tick, ring_expire;
  logic          snz_load, snz_clear, snz_tick, snz_expire;
  logic [TW-1:0] ring_cnt, snooze_cnt;
  logic          unused_cnt;

  assign trigger   = alarm_match & ~match_q;
  assign snooze_ok = (snooze_left != 3'd0);

  // A button that moves the FSM swallows a coincident tick.
  assign ring_tick = alarm_en & (state == RING) & tick_1hz & ~btn_stop
                   & ~(btn_snooze & snooze_ok);
  assign snz_tick  = alarm_en & (state == SNOOZE) & tick_1hz & ~btn_stop;

`ifdef ALARM_AUTO_SNOOZE_EN
  assign auto_snooze = snooze_ok;
`else
  assign auto_snooze = 1'b0;
`endif

  // Counts are observed only through the expiry pulses.
  assign unused_cnt = ^{ring_cnt, snooze_cnt};

  sec_down_timer #(.WIDTH(TW)) u_ring_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (ring_load),
    .load_val (RING_LOAD),
    .tick     (ring_tick),
    .clear    (ring_clear),
    .count    (ring_cnt),
    .expire   (ring_expire)
  );

  sec_down_timer #(.WIDTH(TW)) u_snooze_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (snz_load),
    .load_val (SNOOZE_LOAD),
    .tick     (snz_tick),
    .clear    (snz_clear),
    .count    (snooze_cnt),
    .expire   (snz_expire)
  );

  always_comb begin
    state_n       = state;
    beep_n        = beep_phase;
    snooze_left_n = snooze_left;
    to_idle       = 1'b0;
    to_snooze     = 1'b0;
    ring_load     = 1'b0;
    ring_clear    = 1'b0;
    snz_load      = 1'b0;
    snz_clear     = 1'b0;

    if (!alarm_en) begin
      to_idle = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            state_n       = RING;
            ring_load     = 1'b1;
            snooze_left_n = SNOOZE_INIT;
            beep_n        = 1'b1;
          end
        end
        RING: begin
          if (btn_stop) begin
            to_idle = 1'b1;
          end else if (btn_snooze && snooze_ok) begin
            to_snooze = 1'b1;
          end else if (ring_expire) begin
            if (auto_snooze) to_snooze = 1'b1;
            else             to_idle   = 1'b1;
          end else if (tick_1hz) begin
            beep_n = ~beep_phase;
          end
        end
        SNOOZE: begin
          if (btn_stop) begin
            to_idle = 1'b1;
          end else if (snz_expire) begin
            state_n   = RING;
            ring_load = 1'b1;
            snz_clear = 1'b1;
            beep_n    = 1'b1;
          end
        end
        default: to_idle = 1'b1;
      endcase
    end

    if (to_idle) begin
      state_n       = IDLE;
      beep_n        = 1'b0;
      snooze_left_n = 3'd0;
      ring_clear    = 1'b1;
      snz_clear     = 1'b1;
    end else if (to_snooze) begin
      state_n       = SNOOZE;
      beep_n        = 1'b0;
      snooze_left_n = snooze_left - 3'd1;
      ring_clear    = 1'b1;
      snz_load      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      match_q     <= 1'b0;
      beep_phase  <= 1'b0;
      snooze_left <= 3'd0;
      sound       <= 1'b0;
      ringing     <= 1'b0;
      snoozing    <= 1'b0;
    end else begin
      state       <= state_n;
      match_q     <= alarm_match;
      beep_phase  <= beep_n;
      snooze_left <= snooze_left_n;
      sound       <= (state_n == RING) & beep_n;
      ringing     <= (state_n == RING);
      snoozing    <= (state_n == SNOOZE);
    end
  end

endmodule

`default_nettype wire
